// File: rtl/sprite_dma_ctrl.sv
// Bus-stealing sprite DMA sequencer for the cpu6502 memory bus.
// A CPU store to TRIGGER_ADDR latches a source page, the CPU is halted via
// RDY, then LEN bytes are copied from {page,8'h00} to the DEST_ADDR port.
// All updates happen on posedge clk qualified by cyc_end, so outputs hold
// for a whole CPU bus cycle.
module sprite_dma_ctrl #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004,
  parameter int unsigned LEN          = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cyc_end,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_odata,
  input  logic        cpu_rw,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_rdy,
  output logic        bus_sel,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rw,
  output logic        busy
);

  localparam int unsigned IDX_W = 9;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             parity_q, parity_d;
  logic [7:0]       page_q, page_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rdy_q, rdy_d;
  logic             sel_q, sel_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             rw_q, rw_d;
  logic             busy_q, busy_d;

  logic             trigger_c;
  logic [IDX_W-1:0] idx_inc_c;

  assign trigger_c = (cpu_addr == TRIGGER_ADDR) && !cpu_rw;
  assign idx_inc_c = idx_q + IDX_W'(1);

  assign cpu_rdy   = rdy_q;
  assign bus_sel   = sel_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_rw    = rw_q;
  assign busy      = busy_q;

  // State register, advanced once per CPU bus cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else if (cyc_end) begin
      state_q <= state_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trigger_c) state_d = S_HALT;
      S_HALT:  if (cpu_rw) state_d = parity_q ? S_ALIGN : S_READ;
      S_ALIGN: state_d = S_READ;
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = (idx_q == LAST_IDX) ? S_IDLE : S_READ;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the datapath and bus outputs for the coming CPU cycle
  always_comb begin
    parity_d = ~parity_q;
    page_d   = page_q;
    idx_d    = idx_q;
    rdy_d    = rdy_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (trigger_c) begin
          page_d = cpu_odata;
          idx_d  = '0;
          rdy_d  = 1'b0;
          busy_d = 1'b1;
        end
      end
      S_HALT: begin
        // Writes ignore RDY, so only a read cycle proves the CPU is stopped
        if (cpu_rw) begin
          sel_d  = 1'b1;
          rw_d   = 1'b1;
          addr_d = {page_q, idx_q[7:0]};
        end
      end
      S_ALIGN: begin
        addr_d = {page_q, idx_q[7:0]};
        rw_d   = 1'b1;
      end
      S_READ: begin
        wdata_d = mem_rdata;
        addr_d  = DEST_ADDR;
        rw_d    = 1'b0;
      end
      S_WRITE: begin
        rw_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          sel_d  = 1'b0;
          rdy_d  = 1'b1;
          busy_d = 1'b0;
        end else begin
          idx_d  = idx_inc_c;
          addr_d = {page_q, idx_inc_c[7:0]};
        end
      end
      default: begin
        sel_d  = 1'b0;
        rdy_d  = 1'b1;
        busy_d = 1'b0;
        rw_d   = 1'b1;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
      page_q   <= '0;
      idx_q    <= '0;
      rdy_q    <= 1'b1;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else if (cyc_end) begin
      parity_q <= parity_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      rdy_q    <= rdy_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      busy_q   <= busy_d;
    end
  end

endmodule
